seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 5 +
 rtl/div_trial_sub.sv | 13 +
 rtl/seq_divider.sv | 93 +++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM state encoding and default operand width
package seq_divider_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: WIDTH+1-bit trial subtraction of the divisor from the shifted partial remainder
module div_trial_sub
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_diff,
  output logic             o_borrow
);
  assign {o_borrow, o_diff} = {1'b0, i_rem} - {2'b0, i_dvs};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: WIDTH-bit unsigned restoring divider, one quotient bit per RUN cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_quot, r_remo;
  logic             r_busy, r_done, r_dbz;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_borrow, w_restore;
  logic [WIDTH-1:0] w_next, w_qnext;
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .i_rem   (w_shift),
    .i_dvs   (r_dvs),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );
  // the difference MSB can only be set when the subtraction also borrowed
  assign w_restore = w_borrow | w_diff[WIDTH];
  assign w_next    = w_restore ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_qnext   = {r_dvd[WIDTH-2:0], ~w_restore};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_dvd <= dividend;
          r_dvs <= divisor;
          r_rem <= '0;
          r_cnt <= '0;
          if (divisor == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_quot  <= '1;
            r_remo  <= dividend;
            r_dbz   <= 1'b1;
          end else begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_rem <= w_next;
          r_dvd <= w_qnext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_qnext;
            r_remo  <= w_next;
            r_dbz   <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and held-start checks of seq_divider with WIDTH=8
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int         errors = 0;
  int         checks = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int   cyc;
    logic bseen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    bseen = busy;
    while (!done && cyc < 30) begin
      step();
      cyc++;
      bseen |= busy;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    chk({tag, "_busy_seen"}, 32'(bseen), 32'(!ez));
    step();
    chk({tag, "_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    int         cyc;
    int         dones;
    logic [7:0] ra, rb;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_q", 32'(quotient), 32'(0));
    chk("rst_r", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;
    step();

    run_div("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
    run_div("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    run_div("d5_9", 8'd5, 8'd9, 9, 8'd0, 8'd5, 1'b0);
    run_div("d0_3", 8'd0, 8'd3, 9, 8'd0, 8'd0, 1'b0);
    run_div("d200_200", 8'd200, 8'd200, 9, 8'd1, 8'd0, 1'b0);
    run_div("d77_0", 8'd77, 8'd0, 1, 8'd255, 8'd77, 1'b1);
    run_div("d9_4", 8'd9, 8'd4, 9, 8'd2, 8'd1, 1'b0);

    // start and operand changes while running must be ignored
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = 8'd3;
    divisor  = 8'd0;
    cyc      = 4;
    while (!done && cyc < 30) begin
      step();
      cyc++;
    end
    chk("ign_lat", 32'(cyc), 32'(9));
    chk("ign_q", 32'(quotient), 32'(14));
    chk("ign_r", 32'(remainder), 32'(2));
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      dones += int'(done);
    end
    chk("ign_no_second_done", 32'(dones), 32'(0));
    chk("ign_idle_busy", 32'(busy), 32'(0));

    // asynchronous reset in the middle of a division
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_q", 32'(quotient), 32'(0));
    chk("arst_r", 32'(remainder), 32'(0));
    chk("arst_dbz", 32'(div_by_zero), 32'(0));
    step();
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      dones += int'(done);
    end
    chk("arst_no_done", 32'(dones), 32'(0));
    run_div("d63_8", 8'd63, 8'd8, 9, 8'd7, 8'd7, 1'b0);

    // start held high: back-to-back divisions every 10 cycles
    ra       = 8'($urandom_range(255, 0));
    rb       = 8'($urandom_range(255, 1));
    dividend = ra;
    divisor  = rb;
    start    = 1'b1;
    step();
    for (int i = 0; i < 200; i++) begin
      cyc = 1;
      while (!done && cyc < 30) begin
        step();
        cyc++;
      end
      chk("held_lat", 32'(cyc), 32'(9));
      chk("held_q", 32'(quotient), 32'(ra / rb));
      chk("held_r", 32'(remainder), 32'(ra % rb));
      ra       = 8'($urandom_range(255, 0));
      rb       = 8'($urandom_range(255, 1));
      dividend = ra;
      divisor  = rb;
      step();
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
